// File: rtl/pipelined_instruction_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_instruction_decoder_if
// Brief    : Instruction input, microcode ROM and decoded output bundle for
//            the pipelined instruction decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_instruction_decoder_if #(
    parameter int UADDR_WIDTH = 6,
    parameter int UCODE_WIDTH = 32,
    parameter int PC_WIDTH    = 32
) ();
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_instruction;
    logic [PC_WIDTH-1:0]    in_pc;
    logic                   rom_en;
    logic [UADDR_WIDTH-1:0] rom_addr;
    logic [UCODE_WIDTH-1:0] rom_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [UCODE_WIDTH-1:0] out_microcode;
    logic [24:0]            out_instruction_data;
    logic [PC_WIDTH-1:0]    out_pc;
    logic                   out_illegal;

    // Decoder side
    modport slave (
        input  flush, in_valid, in_instruction, in_pc, rom_data, out_ready,
        output in_ready, rom_en, rom_addr, out_valid, out_microcode,
               out_instruction_data, out_pc, out_illegal
    );

    // Fetch / ROM / execute side
    modport master (
        output flush, in_valid, in_instruction, in_pc, rom_data, out_ready,
        input  in_ready, rom_en, rom_addr, out_valid, out_microcode,
               out_instruction_data, out_pc, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_instruction_decoder
// Brief    : Opcode classifier driving an external microcode ROM; sideband is
//            pipelined alongside the ROM read and results are buffered in a
//            credit-tracked FWFT FIFO so backpressure never drops a ROM word.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_instruction_decoder #(
    parameter int UADDR_WIDTH = 6,
    parameter int UCODE_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 3
) (
    input wire clk,
    input wire rst_n,
    pipelined_instruction_decoder_if.slave bus
);
    localparam int SBW = 25 + PC_WIDTH + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

    logic [2:0]             w_f3;
    logic [5:0]             w_code;
    logic                   w_illegal;
    logic [CW:0]            w_occ;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [SBW-1:0]         w_sb_in;

    logic [ROM_LATENCY-1:0] pipe_v_q;
    logic [SBW-1:0]         pipe_sb_q [ROM_LATENCY];
    logic [UCODE_WIDTH-1:0] fifo_uc_q [FIFO_DEPTH];
    logic [SBW-1:0]         fifo_sb_q [FIFO_DEPTH];
    logic [CW-1:0]          infl_cnt_q, infl_cnt_d;
    logic [CW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [UADDR_WIDTH-1:0] rom_addr_q;

    assign w_f3 = bus.in_instruction[14:12];

    // Opcode classification into a 6-bit microcode entry point
    always_comb begin
        w_code    = 6'h00;
        w_illegal = 1'b0;
        case (bus.in_instruction[6:0])
            7'b0110111: w_code = 6'h01;
            7'b0010111: w_code = 6'h02;
            7'b1101111: w_code = 6'h03;
            7'b1100111: w_code = 6'h04;
            7'b1100011: w_code = {3'b001, w_f3};
            7'b0000011: w_code = {3'b010, w_f3};
            7'b0100011: w_code = {3'b011, w_f3};
            7'b0010011: w_code = {1'b1, bus.in_instruction[30] & (w_f3 == 3'b101), 1'b0, w_f3};
            7'b0110011: w_code = {1'b1, bus.in_instruction[30], 1'b1, w_f3};
            default:    w_illegal = 1'b1;
        endcase
    end

    // Credits: every accepted read owns a FIFO slot until it is popped, so
    // in_ready is a function of registered counts only.
    assign w_occ      = {1'b0, infl_cnt_q} + {1'b0, fifo_cnt_q};
    assign w_in_ready = rst_n & ~bus.flush & (w_occ < DEPTH_OCC);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_push     = pipe_v_q[ROM_LATENCY-1];
    assign w_pop      = bus.out_valid & bus.out_ready;
    assign w_sb_in    = {bus.in_instruction[31:7], bus.in_pc, w_illegal};

    assign bus.in_ready      = w_in_ready;
    assign bus.rom_en        = w_accept;
    assign bus.rom_addr      = w_accept ? UADDR_WIDTH'(w_code) : rom_addr_q;
    assign bus.out_valid     = (fifo_cnt_q != '0);
    assign bus.out_microcode = fifo_uc_q[rd_ptr_q];
    assign {bus.out_instruction_data, bus.out_pc, bus.out_illegal} = fifo_sb_q[rd_ptr_q];

    // Sideband delay line, aligned with the ROM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) pipe_sb_q[i] <= '0;
        end else begin
            pipe_v_q[0]  <= w_accept;
            pipe_sb_q[0] <= w_sb_in;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1] & ~bus.flush;
                pipe_sb_q[i] <= pipe_sb_q[i-1];
            end
        end
    end

    // Next-state for credit counters and FIFO pointers; flush wipes them all
    always_comb begin
        infl_cnt_d = infl_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (bus.flush) begin
            infl_cnt_d = '0;
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   infl_cnt_d = infl_cnt_q + 1'b1;
                2'b01:   infl_cnt_d = infl_cnt_q - 1'b1;
                default: infl_cnt_d = infl_cnt_q;
            endcase
            case ({w_push, w_pop})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
            if (w_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Counter, pointer and last-address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_cnt_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rom_addr_q <= '0;
        end else begin
            infl_cnt_q <= infl_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (w_accept) rom_addr_q <= UADDR_WIDTH'(w_code);
        end
    end

    // FIFO storage; a push while full is only possible together with a pop,
    // and the head is read combinationally before the slot is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_uc_q[i] <= '0;
                fifo_sb_q[i] <= '0;
            end
        end else if (w_push && !bus.flush) begin
            fifo_uc_q[wr_ptr_q] <= bus.rom_data;
            fifo_sb_q[wr_ptr_q] <= pipe_sb_q[ROM_LATENCY-1];
        end
    end

    // Credits must always leave room for a returning ROM word
    always_ff @(posedge clk) begin
        if (rst_n && !bus.flush && w_push && !w_pop)
            assert (fifo_cnt_q < DEPTH_CNT);
    end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_instruction_decoder
// Brief    : Directed bench for two decoder instances (L=1/D=3, L=3/D=5) with
//            a latency-accurate ROM model and a per-instance scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_instruction_decoder;
    typedef struct {
        logic [31:0] uc;
        logic [24:0] data;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rst_n [2];
    logic        flush [2];
    logic        in_valid [2];
    logic        out_ready [2];
    logic [31:0] ins [2];
    logic [31:0] pcv [2];
    logic        in_ready_o [2];
    logic        out_valid_o [2];
    logic        rom_en_o [2];
    logic        ill_o [2];
    logic [7:0]  addr_o [2];
    logic [31:0] uc_o [2];
    logic [31:0] pc_o [2];
    logic [24:0] data_o [2];
    int          pend [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference classification, written from the opcode table
    function automatic logic [5:0] ref_addr(input logic [31:0] i, output logic ill);
        logic [2:0] f;
        f   = i[14:12];
        ill = 1'b0;
        if (i[6:0] == 7'h37) return 6'h01;
        if (i[6:0] == 7'h17) return 6'h02;
        if (i[6:0] == 7'h6F) return 6'h03;
        if (i[6:0] == 7'h67) return 6'h04;
        if (i[6:0] == 7'h63) return {3'd1, f};
        if (i[6:0] == 7'h03) return {3'd2, f};
        if (i[6:0] == 7'h23) return {3'd3, f};
        if (i[6:0] == 7'h13) return {2'b10, 1'b0, f} | ((i[30] && f == 3'd5) ? 6'h10 : 6'h00);
        if (i[6:0] == 7'h33) return {2'b10, 1'b1, f} | (i[30] ? 6'h10 : 6'h00);
        ill = 1'b1;
        return 6'h00;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L  = (g == 0) ? 1 : 3;
        localparam int D  = (g == 0) ? 3 : 5;
        localparam int UA = (g == 0) ? 6 : 8;

        pipelined_instruction_decoder_if #(.UADDR_WIDTH(UA), .UCODE_WIDTH(32), .PC_WIDTH(32)) bus ();

        pipelined_instruction_decoder #(
            .UADDR_WIDTH(UA), .UCODE_WIDTH(32), .PC_WIDTH(32),
            .ROM_LATENCY(L), .FIFO_DEPTH(D)
        ) dut (
            .clk(clk),
            .rst_n(rst_n[g]),
            .bus(bus)
        );

        assign bus.flush          = flush[g];
        assign bus.in_valid       = in_valid[g];
        assign bus.in_instruction = ins[g];
        assign bus.in_pc          = pcv[g];
        assign bus.out_ready      = out_ready[g];
        assign in_ready_o[g]      = bus.in_ready;
        assign out_valid_o[g]     = bus.out_valid;
        assign rom_en_o[g]        = bus.rom_en;
        assign ill_o[g]           = bus.out_illegal;
        assign addr_o[g]          = 8'(bus.rom_addr);
        assign uc_o[g]            = bus.out_microcode;
        assign pc_o[g]            = bus.out_pc;
        assign data_o[g]          = bus.out_instruction_data;

        // External ROM: word = 0xAAAA0000 | addr, L cycles after rom_en; not reset
        logic [L-1:0]  rv = '0;
        logic [UA-1:0] ra [L];
        always @(posedge clk) begin
            for (int i = L - 1; i > 0; i--) begin
                rv[i] <= rv[i-1];
                ra[i] <= ra[i-1];
            end
            rv[0] <= bus.rom_en;
            ra[0] <= bus.rom_addr;
        end
        assign bus.rom_data = rv[L-1] ? (32'hAAAA0000 | 32'(ra[L-1])) : 32'hDEADBEEF;

        // Scoreboard: push at input handshake, pop/compare at output handshake
        exp_t       q [$];
        exp_t       e;
        logic [5:0] a;
        logic       il;
        always @(negedge clk) begin
            if (!rst_n[g]) begin
                q.delete();
            end else begin
                if (bus.in_valid && bus.in_ready) begin
                    a = ref_addr(bus.in_instruction, il);
                    check("rom_en_accept", bus.rom_en, 1'b1);
                    check("rom_addr", 64'(bus.rom_addr), 64'(a));
                    q.push_back('{32'hAAAA0000 | 32'(a), bus.in_instruction[31:7], bus.in_pc, il});
                end else begin
                    check("rom_en_idle", bus.rom_en, 1'b0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_out", bus.out_valid, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check("out_microcode", bus.out_microcode, e.uc);
                        check("out_instr_data", bus.out_instruction_data, e.data);
                        check("out_pc", bus.out_pc, e.pc);
                        check("out_illegal", bus.out_illegal, e.ill);
                    end
                end
                if (bus.flush) q.delete();
            end
            pend[g] = q.size();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic v, input logic [31:0] i, input logic [31:0] p);
        in_valid[k] = v;
        ins[k]      = i;
        pcv[k]      = p;
    endtask

    task automatic drain(input int k, input string tag);
        int n = 0;
        while (pend[k] != 0 && n < 40) begin
            step();
            n++;
        end
        check(tag, pend[k], 0);
    endtask

    logic [31:0] b2b [3]  = '{32'h002081B3, 32'h402081B3, 32'h4010D093};
    logic [31:0] bp [4]   = '{32'h00100093, 32'h0000A103, 32'h0020A223, 32'h00208463};
    logic [31:0] ilg [4]  = '{32'h00000000, 32'h12345137, 32'hFFFFFFFF, 32'h0000006F};

    initial begin
        int          idx;
        int          nacc;
        logic [31:0] h_uc;
        logic [31:0] h_pc;

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; flush[k] = 1'b0; in_valid[k] = 1'b0;
            out_ready[k] = 1'b0; ins[k] = '0; pcv[k] = '0;
        end

        // Reset state, with a request presented that must be ignored
        repeat (2) @(posedge clk);
        #1;
        put(0, 1'b1, 32'h000010B7, 32'h0);
        #1;
        check("rst_in_ready", in_ready_o[0], 1'b0);
        check("rst_out_valid", out_valid_o[0], 1'b0);
        check("rst_rom_en", rom_en_o[0], 1'b0);
        check("rst_rom_addr", addr_o[0], 8'h00);
        check("rst_out_microcode", uc_o[0], 32'h0);
        check("rst_out_pc", pc_o[0], 32'h0);
        put(0, 1'b0, 32'h0, 32'h0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        check("rel_in_ready0", in_ready_o[0], 1'b1);
        check("rel_in_ready1", in_ready_o[1], 1'b1);

        // Single LUI, L=1: out_valid two cycles after accept
        out_ready[0] = 1'b1;
        step();
        put(0, 1'b1, 32'h000010B7, 32'h100);
        @(negedge clk);
        check("lui_rom_addr", addr_o[0], 8'h01);
        step();
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("lui_not_yet", out_valid_o[0], 1'b0);
        step();
        @(negedge clk);
        check("lui_out_valid", out_valid_o[0], 1'b1);
        check("lui_microcode", uc_o[0], 32'hAAAA0001);
        check("lui_instr_data", data_o[0], 25'h0000021);
        check("lui_pc", pc_o[0], 32'h100);
        check("lui_illegal", ill_o[0], 1'b0);
        drain(0, "lui_drain");

        // Back-to-back ADD/SUB/SRAI with no backpressure
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 3) put(0, 1'b1, b2b[i], 32'h200 + 32'(4 * i));
            else       in_valid[0] = 1'b0;
            @(negedge clk);
            if (i < 3) check("b2b_in_ready", in_ready_o[0], 1'b1);
            if (i == 0) check("b2b_addr_add", addr_o[0], 8'h28);
            if (i == 1) check("b2b_addr_sub", addr_o[0], 8'h38);
            if (i == 2) check("b2b_addr_srai", addr_o[0], 8'h35);
            if (i >= 2) check("b2b_out_valid", out_valid_o[0], (i < 5) ? 1'b1 : 1'b0);
        end
        drain(0, "b2b_drain");

        // Backpressure: continuous in_valid, out_ready low
        out_ready[0] = 1'b0;
        idx  = 0;
        nacc = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            put(0, 1'b1, bp[idx], 32'h300 + 32'(4 * idx));
            @(negedge clk);
            if (in_ready_o[0]) begin
                nacc++;
                idx++;
            end
        end
        check("bp_accepts", nacc, 3);
        check("bp_in_ready_low", in_ready_o[0], 1'b0);
        h_uc = uc_o[0];
        h_pc = pc_o[0];
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        check("bp_head_valid", out_valid_o[0], 1'b1);
        check("bp_head_uc_stable", uc_o[0], h_uc);
        check("bp_head_pc_stable", pc_o[0], h_pc);
        check("bp_head_first", pc_o[0], 32'h300);
        step();
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_ready_at_pop", in_ready_o[0], 1'b0);
        step();
        @(negedge clk);
        check("bp_ready_after_pop", in_ready_o[0], 1'b1);
        drain(0, "bp_drain");

        // Illegal encodings interleaved with legal ones
        for (int i = 0; i < 4; i++) begin
            step();
            put(0, 1'b1, ilg[i], 32'h400 + 32'(4 * i));
            @(negedge clk);
            check("ilg_in_ready", in_ready_o[0], 1'b1);
            if (i % 2 == 0) check("ilg_rom_addr", addr_o[0], 8'h00);
        end
        step();
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("ilg_out_illegal", ill_o[0], 1'b1);
        drain(0, "ilg_drain");

        // Flush with two entries buffered and one in flight
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            put(0, 1'b1, bp[i], 32'h500 + 32'(4 * i));
            @(negedge clk);
        end
        step();
        put(0, 1'b1, 32'h00000097, 32'h50C);
        flush[0] = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready_o[0], 1'b0);
        check("flush_pre_valid", out_valid_o[0], 1'b1);
        step();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid_o[0], 1'b0);
        check("flush_in_ready_back", in_ready_o[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("flush_no_late", out_valid_o[0], 1'b0);
        end
        out_ready[0] = 1'b1;
        step();
        put(0, 1'b1, 32'h00000097, 32'h600);
        @(negedge clk);
        step();
        in_valid[0] = 1'b0;
        drain(0, "flush_drain");

        // Asynchronous reset mid-stream on the L=3, DEPTH=5 instance
        out_ready[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            put(1, 1'b1, bp[i], 32'h700 + 32'(4 * i));
            @(negedge clk);
            check("rst1_in_ready", in_ready_o[1], 1'b1);
        end
        step();
        in_valid[1] = 1'b0;
        step();
        #2;
        check("rst1_pre_valid", out_valid_o[1], 1'b1);
        rst_n[1] = 1'b0;
        #1;
        check("rst1_async_valid", out_valid_o[1], 1'b0);
        check("rst1_async_ready", in_ready_o[1], 1'b0);
        put(1, 1'b1, 32'h00000097, 32'h0);
        #1;
        check("rst1_async_rom_en", rom_en_o[1], 1'b0);
        step();
        in_valid[1] = 1'b0;
        rst_n[1]    = 1'b1;
        #1;
        check("rst1_rel_ready", in_ready_o[1], 1'b1);
        out_ready[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst1_no_stale", out_valid_o[1], 1'b0);
            step();
        end
        put(1, 1'b1, 32'h0000A103, 32'h800);
        @(negedge clk);
        check("rst1_new_addr", addr_o[1], 8'h12);
        step();
        in_valid[1] = 1'b0;
        drain(1, "rst1_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
Decode stage between fetch and execute. Accepts 32-bit instructions over a valid/ready handshake and classifies the opcode into a microcode ROM address. It drives an external synchronous microcode ROM with configurable read latency and returns microcode plus instruction payload over a second valid/ready handshake. An internal credit-tracked output FIFO absorbs backpressure, so no ROM read is ever lost.

Parameters:
UADDR_WIDTH, 6, microcode ROM address width; must be >= 6; lookup codes are zero-extended.
UCODE_WIDTH, 32, microcode word width.
PC_WIDTH, 32, width of the PC sideband carried alongside each instruction.
ROM_LATENCY, 1, cycles from rom_en to valid rom_data; legal range 1..4.
FIFO_DEPTH, 3, output FIFO entries; must be >= ROM_LATENCY+2 for full throughput.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discards in-flight and buffered entries
in_valid  in  1  instruction present
in_ready  out  1  decoder can accept
in_instruction  in  32  raw instruction
in_pc  in  PC_WIDTH  instruction address
rom_en  out  1  ROM read strobe
rom_addr  out  UADDR_WIDTH  ROM read address
rom_data  in  UCODE_WIDTH  ROM word, valid ROM_LATENCY cycles after rom_en
out_valid  out  1  decoded entry available
out_ready  in  1  consumer accepts
out_microcode  out  UCODE_WIDTH  microcode word
out_instruction_data  out  25  instruction[31:7]
out_pc  out  PC_WIDTH  PC of entry
out_illegal  out  1  opcode not recognised

Behaviour:
- Reset (async assert, sync release): FIFO count 0, in-flight count 0, all pipeline valid bits 0, out_valid 0, all data outputs 0, rom_en 0.
- Lookup is combinational on in_instruction, with f3 = instruction[14:12]:
  - 0110111 LUI -> 0x01; 0010111 AUIPC -> 0x02; 1101111 JAL -> 0x03; 1100111 JALR -> 0x04.
  - 1100011 BRANCH -> {001,f3}; 0000011 LOAD -> {010,f3}; 0100011 STORE -> {011,f3}.
  - 0010011 OP-IMM -> {1, instruction[30]&(f3==101), 0, f3}.
  - 0110011 OP -> {1, instruction[30], 1, f3}.
  - Any other opcode -> 0x00 with illegal=1; instruction[1:0]!=11 is illegal.
- Accept when in_valid & in_ready. In the same cycle: rom_en=1, rom_addr=lookup. rom_en is 0 in all other cycles. rom_addr holds its last value when idle.
- Sideband (instruction[31:7], pc, illegal) travels through a ROM_LATENCY-deep register pipeline with a valid bit per stage, aligned with rom_data.
- Stage-L valid writes {rom_data, sideband} into the FIFO at the end of that cycle. Accept in cycle N gives out_valid in cycle N+ROM_LATENCY+1 if the FIFO was empty.
- Credits: occupancy = in-flight + FIFO count, both registered. in_ready = !flush & (occupancy < FIFO_DEPTH). in_ready never depends combinationally on out_ready.
- Occupancy updates each cycle: +1 on accept, -1 on output handshake. Simultaneous accept and pop leaves it unchanged. The FIFO never overflows by construction; an internal assertion checks this.
- FIFO is first-word-fall-through. Outputs are driven from the head entry. The head is stable while out_valid & !out_ready.
- Pointer wrap is modulo FIFO_DEPTH, and non-power-of-two depths are supported. Simultaneous push and pop is legal when the FIFO is full or empty-with-incoming.
- Data outputs when out_valid=0: hold the last head value (don't-care for checking).
- flush (registered effect): at the next edge, clear all pipeline valid bits, the FIFO count, pointers and occupancy. in_ready=0 and no accept occur during the flush cycle. ROM returns for flushed reads are ignored. out_valid=0 in the cycle after flush.
- Reset mid-operation: all valid state clears immediately. Outstanding ROM reads are discarded.

Test Plan:
- Single LUI 0x000010B7, pc=0x100, ROM returns 0xAAAA0001 at L=1 -> rom_addr=0x01 in accept cycle; out_valid 2 cycles later with microcode 0xAAAA0001, instruction_data=0x0000021, pc=0x100, illegal=0.
- Back-to-back ADD 0x002081B3, SUB 0x402081B3, SRAI 0x4010D093 with out_ready=1 -> rom_addr 0x28, 0x38, 0x35 on consecutive cycles; three outputs on consecutive cycles, in order; in_ready stays 1.
- out_ready=0 with continuous in_valid, DEPTH=3, L=1 -> exactly 3 accepts, then in_ready=0; out head stable. Raising out_ready drains entries in order, and in_ready returns 1 one cycle after the first pop.
- Illegal 0x00000000 and 0xFFFFFFFF -> rom_addr=0x00, out_illegal=1, entries still delivered in order.
- flush asserted with 1 entry in flight and 2 buffered -> in_ready=0 that cycle; next cycle out_valid=0, occupancy 0; the late ROM return produces no output.
- rst_n pulsed low mid-stream at L=3, DEPTH=5 -> out_valid, rom_en and in_ready (=0 during reset) respond asynchronously; after release in_ready=1 and no stale entry emerges.
